// File: rtl/led7_scan_display.sv
// ============================================================================
// Module   : led7_scan_display
// Summary  : 8-bit binary to 3-digit BCD (sequential double-dabble) driving a
//            4-digit multiplexed common-anode 7-segment display, zero-blanked.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led7_scan_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] q,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int                 CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]         SEG_BLANK = 7'b1111111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [19:0]      shreg_q,   shreg_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       q_cap_q,   q_cap_d;
    logic [7:0]       q_last_q,  q_last_d;
    logic [3:0]       d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
    logic [CNT_W-1:0] refresh_q, refresh_d;
    logic [1:0]       idx_q,     idx_d;
    logic [6:0]       seg_q,     seg_d;
    logic [3:0]       an_q,      an_d;

    logic [19:0]      adj;
    logic [3:0]       digit;
    logic             blank;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble step: correct each BCD nibble before the shift.
    always_comb begin
        adj = shreg_q;
        for (int i = 0; i < 3; i++) begin
            if (shreg_q[8 + 4*i +: 4] >= 4'd5) begin
                adj[8 + 4*i +: 4] = shreg_q[8 + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        q_cap_d   = q_cap_q;
        q_last_d  = q_last_q;
        d0_d      = d0_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        case (state_q)
            ST_IDLE: begin
                if (q != q_last_q) begin
                    shreg_d   = {12'b0, q};
                    q_cap_d   = q;
                    bit_cnt_d = 3'd0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d   = {adj[18:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                d2_d     = shreg_q[19:16];
                d1_d     = shreg_q[15:12];
                d0_d     = shreg_q[11:8];
                q_last_d = q_cap_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        refresh_d = refresh_q + CNT_W'(1);
        idx_d     = idx_q;
        if (refresh_q == CNT_MAX) begin
            refresh_d = '0;
            idx_d     = idx_q + 2'd1;
        end
    end

    // Outputs are registered from the current idx/digits, so seg and an move together.
    always_comb begin
        digit = d0_q;
        blank = 1'b0;
        case (idx_q)
            2'd0: begin digit = d0_q; blank = 1'b0; end
            2'd1: begin digit = d1_q; blank = (d2_q == 4'd0) && (d1_q == 4'd0); end
            2'd2: begin digit = d2_q; blank = (d2_q == 4'd0); end
            default: begin digit = 4'd0; blank = 1'b1; end
        endcase
        seg_d = blank ? SEG_BLANK : seg_of(digit);
        an_d  = ~(4'b0001 << idx_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            q_cap_q   <= '0;
            q_last_q  <= '0;
            d0_q      <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            refresh_q <= '0;
            idx_q     <= '0;
            seg_q     <= SEG_BLANK;
            an_q      <= 4'b1111;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            q_cap_q   <= q_cap_d;
            q_last_q  <= q_last_d;
            d0_q      <= d0_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_led7_scan_display.sv
// ============================================================================
// Module   : tb_led7_scan_display
// Summary  : Scoreboard bench for led7_scan_display with a short refresh period.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led7_scan_display;

    localparam int DIV = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] q     = 8'd0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t exp_q[$];
    int   val_q[$];

    led7_scan_display #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q),
        .seg   (seg),
        .an    (an),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] lut(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected {an,seg} for the four digit slots of a frame showing v.
    task automatic push_frame(input int v);
        int h, t, o;
        exp_t e;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        e.an = 4'b1110; e.seg = lut(o);                                  exp_q.push_back(e);
        e.an = 4'b1101; e.seg = (h == 0 && t == 0) ? 7'h7F : lut(t);     exp_q.push_back(e);
        e.an = 4'b1011; e.seg = (h == 0) ? 7'h7F : lut(h);               exp_q.push_back(e);
        e.an = 4'b0111; e.seg = 7'h7F;                                   exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b0;
        q     = 8'd0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold: an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1", an, seg, dp);
        end
        push_frame(0);
        reset = 1'b1;
        for (int d = 0; d < 4; d++) begin
            e = exp_q.pop_front();
            for (int c = 0; c < DIV; c++) begin
                @(negedge clk);
                n_tests++;
                if (an !== e.an || seg !== e.seg) begin
                    n_fail++;
                    $display("FAIL reset_frame d%0d c%0d: an=%b seg=%b, want an=%b seg=%b",
                             d, c, an, seg, e.an, e.seg);
                end
            end
        end
    endtask

    task automatic test_values();
        int   vals[3] = '{253, 7, 40};
        exp_t e;
        logic [3:0] prev;
        bit   found;
        foreach (vals[k]) begin
            @(negedge clk);
            q = 8'(vals[k]);
            push_frame(vals[k]);
            repeat (12) @(negedge clk);
            prev  = an;
            found = 1'b0;
            for (int w = 0; w < 40 && !found; w++) begin
                @(negedge clk);
                if (prev == 4'b0111 && an == 4'b1110) found = 1'b1;
                prev = an;
            end
            n_tests++;
            if (!found) begin
                n_fail++;
                $display("FAIL value_%0d_sync: an=%b, want a 0111->1110 transition within 40 cycles", vals[k], an);
                repeat (4) void'(exp_q.pop_front());
            end else begin
                for (int d = 0; d < 4; d++) begin
                    e = exp_q.pop_front();
                    for (int c = 0; c < DIV; c++) begin
                        if (d != 0 || c != 0) @(negedge clk);
                        n_tests++;
                        if (an !== e.an || seg !== e.seg) begin
                            n_fail++;
                            $display("FAIL value_%0d d%0d c%0d: an=%b seg=%b, want an=%b seg=%b",
                                     vals[k], d, c, an, seg, e.an, e.seg);
                        end
                    end
                end
            end
        end
    endtask

    // Display holds 40 beforehand; q moves 255 -> 0 three cycles into the shift.
    task automatic test_change_mid();
        int v;
        @(negedge clk);
        q = 8'd255;
        val_q.push_back(255);
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        q = 8'd0;
        val_q.push_back(0);
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if ({dut.d2_q, dut.d1_q, dut.d0_q} !== 12'h040) begin
            n_fail++;
            $display("FAIL change_mid_early: digits=%h at N+8, want 040", {dut.d2_q, dut.d1_q, dut.d0_q});
        end
        @(posedge clk);
        #1;
        v = val_q.pop_front();
        n_tests++;
        if ({dut.d2_q, dut.d1_q, dut.d0_q} !== {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)}) begin
            n_fail++;
            $display("FAIL change_mid_first: digits=%h at N+9, want %0d", {dut.d2_q, dut.d1_q, dut.d0_q}, v);
        end
        repeat (10) @(posedge clk);
        #1;
        v = val_q.pop_front();
        n_tests++;
        if ({dut.d2_q, dut.d1_q, dut.d0_q} !== {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)}) begin
            n_fail++;
            $display("FAIL change_mid_second: digits=%h at N+19, want %0d", {dut.d2_q, dut.d1_q, dut.d0_q}, v);
        end
    endtask

    task automatic test_reset_mid();
        int v;
        @(negedge clk);
        q = 8'd128;
        val_q.push_back(128);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        n_tests++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 ||
            {dut.d2_q, dut.d1_q, dut.d0_q} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_mid_async: an=%b seg=%b dp=%b digits=%h, want 1111 1111111 1 000",
                     an, seg, dp, {dut.d2_q, dut.d1_q, dut.d0_q});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        v = val_q.pop_front();
        n_tests++;
        if ({dut.d2_q, dut.d1_q, dut.d0_q} !== {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)}) begin
            n_fail++;
            $display("FAIL reset_mid_reconvert: digits=%h, want %0d", {dut.d2_q, dut.d1_q, dut.d0_q}, v);
        end
    endtask

    task automatic test_sweep();
        int v;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            q = 8'(k);
            val_q.push_back(k);
            repeat (12) @(posedge clk);
            #1;
            v = val_q.pop_front();
            n_tests++;
            if ({dut.d2_q, dut.d1_q, dut.d0_q} !== {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)}) begin
                n_fail++;
                $display("FAIL sweep_%0d: digits=%h, want %0d", v, {dut.d2_q, dut.d1_q, dut.d0_q}, v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_values();
        test_change_mid();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/led7_scan_display.md
# led7_scan_display

Downstream display stage for the pulse counter. It takes the counter's 8-bit binary value and converts it to three BCD digits with a sequential double-dabble converter. It then drives a 4-digit, common-anode 7-segment display by time-multiplexing the digits, with leading zeros blanked. It sits directly after the counter in the top level, connected to the counter's `q` bus, and drives the board's segment and anode pins.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays selected. Legal range is 2 to 2^20.
- `clk` input 1: system clock. All state is clocked on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `q` input 8: binary value from the counter. It is not assumed synchronous to any event and may change on any cycle.
- `seg` output 7: segments `{g,f,e,d,c,b,a}`, active-low, registered.
- `an` output 4: digit enables, active-low, registered. `an[0]` is the ones digit and `an[3]` is the leftmost digit.
- `dp` output 1: decimal point, active-low. Held at 1 (off).

## Operation
- Converter FSM has three states: IDLE, SHIFT and DONE.
  - IDLE: if `q != q_last`, load a 20-bit shift register with `{12'b0, q}`, clear the bit counter, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each cycle, first add 3 to every BCD nibble that is 5 or more, then shift the whole register left by 1. Do this for 8 cycles (bit counter 0 to 7). After the 8th shift, go to DONE.
  - DONE: copy the three nibbles into the display registers `d2 d1 d0`, set `q_last` to the captured q, and return to IDLE.
- `q` is captured only on the IDLE to SHIFT transition. A change on `q` during SHIFT or DONE does not affect the conversion in progress. It is picked up by the compare in IDLE that follows.
- Scan logic:
  - The refresh counter counts 0 to `REFRESH_DIV-1`.
  - When it wraps, the digit index `idx` advances 0→1→2→3→0.
  - The index runs continuously and is independent of the converter.
- Digit decode:
  - `idx` 0 shows `d0`. It is always shown, so a value of 0 displays "0".
  - `idx` 1 shows `d1`, or blank if `d2 == 0` and `d1 == 0`.
  - `idx` 2 shows `d2`, or blank if `d2 == 0`.
  - `idx` 3 is always blank.
- Segment codes, active-low gfedcba:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111
- `an` is one-hot-low on `idx` (for example `idx` 2 gives 1011). The selected digit is always enabled, even when its segments are blank.

## Timing
- Reset asserted (`reset` = 0), effective immediately without a clock:
  - `seg` = 1111111, `an` = 1111, `dp` = 1
  - `d2 d1 d0` = 0, `q_last` = 0
  - FSM = IDLE, refresh counter = 0, `idx` = 0
- First rising edge after reset release: `an` = 1110 and `seg` = 1000000.
- Conversion latency: with `q` sampled at edge N, the display registers update at edge N+9. `seg` reflects the new value at edge N+10 if that digit is selected at that time. The earliest next capture is edge N+10.
- `an` and `seg` are registered from `idx` and `d*`, so they lag the `idx` change by one cycle. Each digit is enabled for exactly `REFRESH_DIV` cycles, and a full frame is `4*REFRESH_DIV` cycles.
- If a DONE commit and a refresh wrap happen on the same edge, both take effect. The next registered `seg` uses the new `idx` and the new `d*`.
- `an` never has two bits low at once. `seg` and `an` update on the same edge, so there is no cycle where a wrong digit is shown.
- Reset asserted mid-conversion aborts the conversion. After release, the block compares against `q_last` = 0 and reconverts any non-zero `q`.
- 255 converts to 2/5/5. No input value can exceed 3 digits.

## Test plan
- Reset with `REFRESH_DIV` = 4 → while reset is held, `an` = 1111 and `seg` = 1111111. After release, `an` cycles 1110, 1101, 1011, 0111, each held for 4 cycles. `seg` = 1000000 on `an` = 1110 and 1111111 on the other three.
- `q` = 253 held → within 10 cycles of the change: `an` 1110 gives `seg` 0110000, `an` 1101 gives 0010010, `an` 1011 gives 0100100, `an` 0111 gives 1111111.
- `q` = 7 → `an` 1110 gives 1111000. `an` 1101 and 1011 give blank. `q` = 40 → ones shows 1000000, tens shows 0011001, hundreds is blank.
- `q` changes 255 → 0 at 3 cycles into SHIFT → the display first shows 255 (at edge N+9). It then shows 0, with `d*` cleared no later than 20 cycles after the first capture.
- `reset` pulsed low in the middle of SHIFT with `q` = 128 → outputs take their reset values immediately. After release, the display reaches 1/2/8 within 10 cycles.
- Sweep `q` 0..255, waiting 12 cycles at each value → `d2*100 + d1*10 + d0` equals `q` every time, and no nibble ever exceeds 9.
